// File: rtl/memif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memif_pkg
// Brief    : Arbiter state encoding and the 62-bit memory request record.
// Revision : 1.0
// ============================================================================
package memif_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } memif_state_t;

  typedef struct packed {
    logic [3:0]  dqm;
    logic        rw;
    logic [24:0] addr;
    logic [31:0] data;
  } memif_req_t;

  localparam int unsigned c_REQ_W      = 62;
  localparam logic [22:0] c_WORD_MAX   = 23'h7FFFFF;

endpackage
`default_nettype wire

// File: rtl/memif_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : memif_req_fifo
// Brief    : Request FIFO; flags come from a registered occupancy count.
// Revision : 1.0
// ============================================================================
module memif_req_fifo
  import memif_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4
)(
  input  logic                            iCLOCK,
  input  logic                            inRESET,
  input  logic                            iRESET_SYNC,
  input  logic                            iPUSH,
  input  memif_req_t                      iPUSH_DATA,
  input  logic                            iPOP,
  output memif_req_t                      oHEAD,
  output logic                            oFULL,
  output logic                            oEMPTY,
  output logic [$clog2(P_FIFO_DEPTH):0]   oCOUNT
);

  localparam int                 c_PTR_W      = $clog2(P_FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL_COUNT = (c_PTR_W + 1)'(P_FIFO_DEPTH);

  memif_req_t           r_mem [P_FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_push;
  logic                 w_pop;

  assign oFULL  = (r_count == c_FULL_COUNT);
  assign oEMPTY = (r_count == '0);
  assign oCOUNT = r_count;
  assign oHEAD  = r_mem[r_rd_ptr];

  assign w_push = iPUSH && !oFULL;
  assign w_pop  = iPOP && !oEMPTY;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iRESET_SYNC) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wr_ptr] <= iPUSH_DATA;
  end

endmodule
`default_nettype wire

// File: rtl/iboot_memif_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : iboot_memif_arbiter
// Brief    : Hands the memory request path from the boot loader to the CPU.
//            Optional checksum of boot writes: MIST32_IBOOT_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module iboot_memif_arbiter
  import memif_pkg::*;
#(
  parameter int P_FIFO_DEPTH = 4
)(
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iRESET_SYNC,
  input  logic         iIBOOT_VALID,
  input  logic         iIBOOT_REQ_VALID,
  input  logic [3:0]   iIBOOT_REQ_DQM,
  input  logic         iIBOOT_REQ_RW,
  input  logic [24:0]  iIBOOT_REQ_ADDR,
  input  logic [31:0]  iIBOOT_REQ_DATA,
  output logic         oIBOOT_REQ_LOCK,
  input  logic         iCPU_REQ_VALID,
  input  logic [3:0]   iCPU_REQ_DQM,
  input  logic         iCPU_REQ_RW,
  input  logic [24:0]  iCPU_REQ_ADDR,
  input  logic [31:0]  iCPU_REQ_DATA,
  output logic         oCPU_REQ_LOCK,
  output logic         oCPU_RD_VALID,
  output logic [31:0]  oCPU_RD_DATA,
  output logic         oMEM_REQ_VALID,
  output logic [3:0]   oMEM_REQ_DQM,
  output logic         oMEM_REQ_RW,
  output logic [24:0]  oMEM_REQ_ADDR,
  output logic [31:0]  oMEM_REQ_DATA,
  input  logic         iMEM_REQ_LOCK,
  input  logic         iMEM_RD_VALID,
  input  logic [31:0]  iMEM_RD_DATA,
  output logic         oBOOT_DONE,
  output logic [22:0]  oBOOT_WORD_COUNT,
  output logic [31:0]  oBOOT_CHECKSUM
);

  localparam int c_CNT_W = $clog2(P_FIFO_DEPTH) + 1;

  memif_state_t         r_state;
  memif_state_t         w_state_next;
  memif_req_t           w_boot_req;
  memif_req_t           w_cpu_req;
  memif_req_t           w_push_data;
  memif_req_t           w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [c_CNT_W-1:0]   w_count;
  logic                 w_ib_lock;
  logic                 w_cpu_lock;
  logic                 w_boot_acc;
  logic                 w_cpu_acc;
  logic                 w_push;
  logic                 w_pop;
  logic [22:0]          r_word_count;
  logic                 r_rd_valid;
  logic [31:0]          r_rd_data;

  always_comb begin
    w_state_next = r_state;
    w_ib_lock    = 1'b1;
    w_cpu_lock   = 1'b1;
    case (r_state)
      ST_BOOT: begin
        w_ib_lock = w_full;
        if (!iIBOOT_VALID) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_count == '0) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_cpu_lock = w_full;
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         r_state <= ST_BOOT;
    else if (iRESET_SYNC) r_state <= ST_BOOT;
    else                  r_state <= w_state_next;
  end

  // Only the owning side ever sees LOCK=0, so the two accepts never collide.
  assign w_boot_acc  = iIBOOT_REQ_VALID && !w_ib_lock;
  assign w_cpu_acc   = iCPU_REQ_VALID && !w_cpu_lock;
  assign w_push      = w_boot_acc || w_cpu_acc;
  assign w_boot_req  = {iIBOOT_REQ_DQM, iIBOOT_REQ_RW, iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA};
  assign w_cpu_req   = {iCPU_REQ_DQM, iCPU_REQ_RW, iCPU_REQ_ADDR, iCPU_REQ_DATA};
  assign w_push_data = (r_state == ST_RUN) ? w_cpu_req : w_boot_req;
  assign w_pop       = !w_empty && !iMEM_REQ_LOCK;

  memif_req_fifo #(
    .P_FIFO_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iPUSH       (w_push),
    .iPUSH_DATA  (w_push_data),
    .iPOP        (w_pop),
    .oHEAD       (w_head),
    .oFULL       (w_full),
    .oEMPTY      (w_empty),
    .oCOUNT      (w_count)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_word_count <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else if (iRESET_SYNC) begin
      r_word_count <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      if (w_boot_acc && iIBOOT_REQ_RW && (r_word_count != c_WORD_MAX))
        r_word_count <= r_word_count + 23'd1;
      // Boot-phase read returns are dropped here.
      r_rd_valid <= (r_state == ST_RUN) && iMEM_RD_VALID;
      if ((r_state == ST_RUN) && iMEM_RD_VALID)
        r_rd_data <= iMEM_RD_DATA;
    end
  end

`ifdef MIST32_IBOOT_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                         r_checksum <= '0;
    else if (iRESET_SYNC)                 r_checksum <= '0;
    else if (w_boot_acc && iIBOOT_REQ_RW) r_checksum <= r_checksum + iIBOOT_REQ_DATA;
  end

  assign oBOOT_CHECKSUM = r_checksum;
`else
  assign oBOOT_CHECKSUM = 32'h0;
`endif

  assign oIBOOT_REQ_LOCK  = w_ib_lock;
  assign oCPU_REQ_LOCK    = w_cpu_lock;
  assign oMEM_REQ_VALID   = w_pop;
  assign oMEM_REQ_DQM     = w_empty ? 4'h0  : w_head.dqm;
  assign oMEM_REQ_RW      = w_empty ? 1'b0  : w_head.rw;
  assign oMEM_REQ_ADDR    = w_empty ? 25'h0 : w_head.addr;
  assign oMEM_REQ_DATA    = w_empty ? 32'h0 : w_head.data;
  assign oCPU_RD_VALID    = r_rd_valid;
  assign oCPU_RD_DATA     = r_rd_data;
  assign oBOOT_DONE       = (r_state == ST_RUN);
  assign oBOOT_WORD_COUNT = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_iboot_memif_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_iboot_memif_arbiter
// Brief    : Vector table, directed corner sequences and a randomized run
//            against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_iboot_memif_arbiter;

  localparam int DEPTH = 4;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iRESET_SYNC, iIBOOT_VALID;
  logic        iIBOOT_REQ_VALID, iIBOOT_REQ_RW;
  logic [3:0]  iIBOOT_REQ_DQM;
  logic [24:0] iIBOOT_REQ_ADDR;
  logic [31:0] iIBOOT_REQ_DATA;
  logic        iCPU_REQ_VALID, iCPU_REQ_RW;
  logic [3:0]  iCPU_REQ_DQM;
  logic [24:0] iCPU_REQ_ADDR;
  logic [31:0] iCPU_REQ_DATA;
  logic        iMEM_REQ_LOCK, iMEM_RD_VALID;
  logic [31:0] iMEM_RD_DATA;
  logic        oIBOOT_REQ_LOCK, oCPU_REQ_LOCK, oCPU_RD_VALID, oMEM_REQ_VALID, oMEM_REQ_RW, oBOOT_DONE;
  logic [31:0] oCPU_RD_DATA, oMEM_REQ_DATA, oBOOT_CHECKSUM;
  logic [3:0]  oMEM_REQ_DQM;
  logic [24:0] oMEM_REQ_ADDR;
  logic [22:0] oBOOT_WORD_COUNT;

  always #5 iCLOCK = ~iCLOCK;

  iboot_memif_arbiter #(.P_FIFO_DEPTH(DEPTH)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC), .iIBOOT_VALID(iIBOOT_VALID),
    .iIBOOT_REQ_VALID(iIBOOT_REQ_VALID), .iIBOOT_REQ_DQM(iIBOOT_REQ_DQM), .iIBOOT_REQ_RW(iIBOOT_REQ_RW),
    .iIBOOT_REQ_ADDR(iIBOOT_REQ_ADDR), .iIBOOT_REQ_DATA(iIBOOT_REQ_DATA), .oIBOOT_REQ_LOCK(oIBOOT_REQ_LOCK),
    .iCPU_REQ_VALID(iCPU_REQ_VALID), .iCPU_REQ_DQM(iCPU_REQ_DQM), .iCPU_REQ_RW(iCPU_REQ_RW),
    .iCPU_REQ_ADDR(iCPU_REQ_ADDR), .iCPU_REQ_DATA(iCPU_REQ_DATA), .oCPU_REQ_LOCK(oCPU_REQ_LOCK),
    .oCPU_RD_VALID(oCPU_RD_VALID), .oCPU_RD_DATA(oCPU_RD_DATA),
    .oMEM_REQ_VALID(oMEM_REQ_VALID), .oMEM_REQ_DQM(oMEM_REQ_DQM), .oMEM_REQ_RW(oMEM_REQ_RW),
    .oMEM_REQ_ADDR(oMEM_REQ_ADDR), .oMEM_REQ_DATA(oMEM_REQ_DATA), .iMEM_REQ_LOCK(iMEM_REQ_LOCK),
    .iMEM_RD_VALID(iMEM_RD_VALID), .iMEM_RD_DATA(iMEM_RD_DATA),
    .oBOOT_DONE(oBOOT_DONE), .oBOOT_WORD_COUNT(oBOOT_WORD_COUNT), .oBOOT_CHECKSUM(oBOOT_CHECKSUM)
  );

  // Reference model: phase (0 boot, 1 drain, 2 run) and a queue of requests.
  int          m_mode;
  logic [61:0] m_q[$];
  logic [22:0] m_wc;
  logic [31:0] m_sum;
  logic        m_rdv;
  logic [31:0] m_rdd;
  logic [24:0] issued[$];
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic        rv;
    logic [24:0] addr;
    logic [31:0] data;
    logic        e_mv;
    logic [24:0] e_addr;
    logic [31:0] e_data;
    logic [22:0] e_wc;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_q.delete();
    m_wc = '0;
    m_sum = '0;
    m_rdv = 1'b0;
    m_rdd = '0;
  endtask

  task automatic idle();
    iRESET_SYNC = 0; iIBOOT_VALID = 1; iMEM_REQ_LOCK = 0; iMEM_RD_VALID = 0; iMEM_RD_DATA = '0;
    iIBOOT_REQ_VALID = 0; iIBOOT_REQ_DQM = 4'hF; iIBOOT_REQ_RW = 0; iIBOOT_REQ_ADDR = '0; iIBOOT_REQ_DATA = '0;
    iCPU_REQ_VALID = 0; iCPU_REQ_DQM = 4'hF; iCPU_REQ_RW = 0; iCPU_REQ_ADDR = '0; iCPU_REQ_DATA = '0;
  endtask

  task automatic set_boot(input logic v, input logic rw, input logic [24:0] a, input logic [31:0] d);
    iIBOOT_REQ_VALID = v; iIBOOT_REQ_RW = rw; iIBOOT_REQ_ADDR = a; iIBOOT_REQ_DATA = d; iIBOOT_REQ_DQM = 4'hF;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    logic        full, empty, exp_ibl, exp_cpl, exp_mv;
    logic [31:0] exp_sum;
    #1;
    full    = (m_q.size() == DEPTH);
    empty   = (m_q.size() == 0);
    exp_ibl = (m_mode == 0) ? full : 1'b1;
    exp_cpl = (m_mode == 2) ? full : 1'b1;
    exp_mv  = !empty && !iMEM_REQ_LOCK;
    chk("ib_lock", oIBOOT_REQ_LOCK, exp_ibl);
    chk("cpu_lock", oCPU_REQ_LOCK, exp_cpl);
    chk("mem_valid", oMEM_REQ_VALID, exp_mv);
    if (!empty) chk("mem_head", {oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA}, m_q[0]);
    if (oMEM_REQ_VALID) issued.push_back(oMEM_REQ_ADDR);
    if (iRESET_SYNC) begin
      model_reset();
    end else begin
      if (exp_mv) void'(m_q.pop_front());
      if (m_mode == 0 && iIBOOT_REQ_VALID && !full) begin
        m_q.push_back({iIBOOT_REQ_DQM, iIBOOT_REQ_RW, iIBOOT_REQ_ADDR, iIBOOT_REQ_DATA});
        if (iIBOOT_REQ_RW) begin
          if (m_wc != 23'h7FFFFF) m_wc = m_wc + 23'd1;
          m_sum = m_sum + iIBOOT_REQ_DATA;
        end
      end else if (m_mode == 2 && iCPU_REQ_VALID && !full) begin
        m_q.push_back({iCPU_REQ_DQM, iCPU_REQ_RW, iCPU_REQ_ADDR, iCPU_REQ_DATA});
      end
      m_rdv = (m_mode == 2) && iMEM_RD_VALID;
      if (m_rdv) m_rdd = iMEM_RD_DATA;
      if (m_mode == 0 && !iIBOOT_VALID) m_mode = 1;
      else if (m_mode == 1 && empty)    m_mode = 2;
    end
`ifdef MIST32_IBOOT_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 32'h0;
`endif
    @(posedge iCLOCK);
    #1;
    chk("boot_done", oBOOT_DONE, (m_mode == 2));
    chk("word_count", oBOOT_WORD_COUNT, m_wc);
    chk("checksum", oBOOT_CHECKSUM, exp_sum);
    chk("rd_valid", oCPU_RD_VALID, m_rdv);
    chk("rd_data", oCPU_RD_DATA, m_rdd);
  endtask

  task automatic hard_reset();
    idle();
    inRESET = 0;
    repeat (2) @(posedge iCLOCK);
    #1;
    inRESET = 1;
    model_reset();
    #1;
    chk("rst_mem_valid", oMEM_REQ_VALID, 0);
    chk("rst_rd_valid", oCPU_RD_VALID, 0);
    chk("rst_done", oBOOT_DONE, 0);
    chk("rst_ib_lock", oIBOOT_REQ_LOCK, 0);
    chk("rst_cpu_lock", oCPU_REQ_LOCK, 1);
    chk("rst_data_outs", {oMEM_REQ_DQM, oMEM_REQ_RW, oMEM_REQ_ADDR, oMEM_REQ_DATA}, 0);
    chk("rst_status", {oCPU_RD_DATA, oBOOT_CHECKSUM}, 0);
    chk("rst_word_count", oBOOT_WORD_COUNT, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0] = '{1'b1, 25'd0, 32'h11111111, 1'b0, 25'd0, 32'h0,        23'd1};
    vt[1] = '{1'b1, 25'd1, 32'h22222222, 1'b1, 25'd0, 32'h11111111, 23'd2};
    vt[2] = '{1'b1, 25'd2, 32'h33333333, 1'b1, 25'd1, 32'h22222222, 23'd3};
    vt[3] = '{1'b0, 25'd0, 32'h0,        1'b1, 25'd2, 32'h33333333, 23'd3};
    vt[4] = '{1'b0, 25'd0, 32'h0,        1'b0, 25'd0, 32'h0,        23'd3};

    // Three boot writes, each issued one cycle after acceptance.
    hard_reset();
    for (int i = 0; i < 5; i++) begin
      set_boot(vt[i].rv, 1'b1, vt[i].addr, vt[i].data);
      #1;
      chk("vec_mem_valid", oMEM_REQ_VALID, vt[i].e_mv);
      if (vt[i].e_mv) chk("vec_mem_req", {oMEM_REQ_ADDR, oMEM_REQ_DATA}, {vt[i].e_addr, vt[i].e_data});
      tick();
      chk("vec_word_count", oBOOT_WORD_COUNT, vt[i].e_wc);
    end

    // Memory locked: fill to depth, full lock holds through the first pop.
    hard_reset();
    issued.delete();
    iMEM_REQ_LOCK = 1;
    for (int k = 0; k < 4; k++) begin
      set_boot(1'b1, 1'b1, 25'(k), 32'hA0 + 32'(k));
      tick();
    end
    set_boot(1'b1, 1'b1, 25'd4, 32'hA4);
    #1 chk("s035_full_lock", oIBOOT_REQ_LOCK, 1);
    tick();
    chk("s035_accepted", oBOOT_WORD_COUNT, 4);
    iMEM_REQ_LOCK = 0;
    #1;
    chk("s035_lock_on_pop", oIBOOT_REQ_LOCK, 1);
    chk("s035_pop", oMEM_REQ_VALID, 1);
    tick();
    #1 chk("s035_accept_after_pop", oIBOOT_REQ_LOCK, 0);
    tick();
    set_boot(1'b0, 1'b0, 25'd0, 32'd0);
    repeat (4) tick();
    chk("s035_issue_count", issued.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("s035_order", (k < issued.size()) ? issued[k] : 25'h1FFFFFF, k);
    chk("s035_final_count", oBOOT_WORD_COUNT, 5);

    // Boot ends with two entries queued: drain, then hand over to CPU.
    hard_reset();
    issued.delete();
    iMEM_REQ_LOCK = 1;
    set_boot(1'b1, 1'b1, 25'h10, 32'h5); tick();
    set_boot(1'b1, 1'b1, 25'h11, 32'h6); tick();
    set_boot(1'b0, 1'b0, 25'd0, 32'd0);
    iIBOOT_VALID = 0;
    tick();
    #1;
    chk("s036_drain_ib_lock", oIBOOT_REQ_LOCK, 1);
    chk("s036_drain_cpu_lock", oCPU_REQ_LOCK, 1);
    iMEM_REQ_LOCK = 0;
    iMEM_RD_VALID = 1;
    iMEM_RD_DATA  = 32'h12345678;
    n = 0;
    while (!oBOOT_DONE && n < 10) begin
      tick();
      n++;
    end
    chk("s036_run_reached", oBOOT_DONE, 1);
    chk("s036_drained", issued.size(), 2);
    iMEM_RD_VALID = 0;
    iCPU_REQ_VALID = 1; iCPU_REQ_RW = 0; iCPU_REQ_ADDR = 25'h100; iCPU_REQ_DQM = 4'hF;
    #1 chk("s036_cpu_open", oCPU_REQ_LOCK, 0);
    tick();
    iCPU_REQ_VALID = 0;
    #1 chk("s036_cpu_issue", {oMEM_REQ_VALID, oMEM_REQ_RW, oMEM_REQ_ADDR}, {1'b1, 1'b0, 25'h100});
    tick();
    iMEM_RD_VALID = 1; iMEM_RD_DATA = 32'hDEADBEEF;
    tick();
    iMEM_RD_VALID = 0;
    chk("s036_rd_valid", oCPU_RD_VALID, 1);
    chk("s036_rd_data", oCPU_RD_DATA, 32'hDEADBEEF);
    tick();
    chk("s036_rd_valid_drop", oCPU_RD_VALID, 0);

    // Synchronous reset discards a locked, partly filled queue.
    hard_reset();
    iMEM_REQ_LOCK = 1;
    for (int k = 0; k < 3; k++) begin
      set_boot(1'b1, 1'b1, 25'(k + 32), 32'(k));
      tick();
    end
    set_boot(1'b0, 1'b0, 25'd0, 32'd0);
    iRESET_SYNC = 1;
    tick();
    iRESET_SYNC = 0;
    iMEM_REQ_LOCK = 0;
    issued.delete();
    repeat (3) begin
      #1 chk("s037_no_issue", oMEM_REQ_VALID, 0);
      tick();
    end
    chk("s037_issue_count", issued.size(), 0);
    chk("s037_state_boot", {oBOOT_DONE, oIBOOT_REQ_LOCK, oCPU_REQ_LOCK}, 3'b001);
    chk("s037_word_count", oBOOT_WORD_COUNT, 0);

    // Checksum wraps mod 2^32.
    hard_reset();
    set_boot(1'b1, 1'b1, 25'd0, 32'hFFFFFFFF); tick();
    set_boot(1'b1, 1'b1, 25'd1, 32'h00000002); tick();
    set_boot(1'b0, 1'b0, 25'd0, 32'd0); tick();
`ifdef MIST32_IBOOT_CHECKSUM_EN
    chk("s038_checksum", oBOOT_CHECKSUM, 32'h00000001);
`else
    chk("s038_checksum", oBOOT_CHECKSUM, 32'h00000000);
`endif

    // Randomized traffic across the boot/drain/run handover.
    for (int ep = 0; ep < 2; ep++) begin
      hard_reset();
      for (int c = 0; c < 400; c++) begin
        iIBOOT_VALID     = (c < 120 + ep * 60);
        iIBOOT_REQ_VALID = 1'($urandom);
        iIBOOT_REQ_RW    = 1'($urandom);
        iIBOOT_REQ_DQM   = 4'($urandom);
        iIBOOT_REQ_ADDR  = 25'($urandom);
        iIBOOT_REQ_DATA  = $urandom;
        iCPU_REQ_VALID   = 1'($urandom);
        iCPU_REQ_RW      = 1'($urandom);
        iCPU_REQ_DQM     = 4'($urandom);
        iCPU_REQ_ADDR    = 25'($urandom);
        iCPU_REQ_DATA    = $urandom;
        iMEM_REQ_LOCK    = ($urandom_range(0, 3) == 0);
        iMEM_RD_VALID    = 1'($urandom);
        iMEM_RD_DATA     = $urandom;
        iRESET_SYNC      = ($urandom_range(0, 149) == 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iboot_memif_arbiter.md
IBOOT_MEMIF_ARBITER -- requirements
Module: iboot_memif_arbiter

Interface
REQ-001 The module SHALL have parameter P_FIFO_DEPTH, default 4 (power of two, at least 2), giving the number of request FIFO entries.
REQ-002 The clock and reset ports SHALL be: iCLOCK input 1 clock; inRESET input 1, asynchronous active-low reset; iRESET_SYNC input 1, synchronous reset.
REQ-003 The boot status input SHALL be iIBOOT_VALID input 1: boot loader active, high until the image copy ends.
REQ-004 The boot request ports SHALL be: iIBOOT_REQ_VALID input 1; iIBOOT_REQ_DQM input 4; iIBOOT_REQ_RW input 1 (1 = write); iIBOOT_REQ_ADDR input 25; iIBOOT_REQ_DATA input 32; oIBOOT_REQ_LOCK output 1.
REQ-005 The CPU request ports SHALL be: iCPU_REQ_VALID input 1; iCPU_REQ_DQM input 4; iCPU_REQ_RW input 1; iCPU_REQ_ADDR input 25; iCPU_REQ_DATA input 32; oCPU_REQ_LOCK output 1.
REQ-006 The CPU read-return ports SHALL be: oCPU_RD_VALID output 1; oCPU_RD_DATA output 32.
REQ-007 The memory request ports SHALL be: oMEM_REQ_VALID output 1; oMEM_REQ_DQM output 4; oMEM_REQ_RW output 1; oMEM_REQ_ADDR output 25; oMEM_REQ_DATA output 32; iMEM_REQ_LOCK input 1.
REQ-008 The memory read-return ports SHALL be: iMEM_RD_VALID input 1; iMEM_RD_DATA input 32.
REQ-009 The status ports SHALL be: oBOOT_DONE output 1; oBOOT_WORD_COUNT output 23; oBOOT_CHECKSUM output 32.

Function
REQ-010 A request SHALL be accepted in a cycle where its source VALID=1 and its LOCK=0; VALID while LOCK=1 is ignored, and the source re-presents it.
REQ-011 The FSM SHALL have states BOOT, DRAIN and RUN: BOOT->DRAIN when iIBOOT_VALID=0; DRAIN->RUN when the FIFO is empty and no request is in flight; RUN is terminal until reset.
REQ-012 In BOOT the boot side SHALL own the FIFO: oCPU_REQ_LOCK=1 and oIBOOT_REQ_LOCK=FIFO full.
REQ-013 In RUN the CPU side SHALL own the FIFO: oIBOOT_REQ_LOCK=1 and oCPU_REQ_LOCK=FIFO full.
REQ-014 In DRAIN both LOCK outputs SHALL be 1.
REQ-015 The FIFO full and empty flags SHALL be derived from a registered occupancy count (0..P_FIFO_DEPTH).
REQ-016 A simultaneous push and pop SHALL leave the count unchanged.
REQ-017 When the FIFO is full, LOCK SHALL stay 1 even in a cycle with a pop.
REQ-018 oMEM_REQ_VALID SHALL equal (FIFO not empty AND iMEM_REQ_LOCK=0); the head entry is popped in that same cycle.
REQ-019 oMEM_REQ_DQM/RW/ADDR/DATA SHALL present the FIFO head whenever the FIFO is not empty.
REQ-020 The minimum latency from acceptance to oMEM_REQ_VALID SHALL be 1 cycle; order is strictly FIFO.
REQ-021 Boot-side reads (RW=0) SHALL be accepted and forwarded, but their read return is discarded.
REQ-022 iMEM_RD_VALID/iMEM_RD_DATA SHALL be registered to oCPU_RD_VALID/oCPU_RD_DATA (1-cycle latency) only in RUN; in BOOT and DRAIN oCPU_RD_VALID=0.
REQ-023 oBOOT_DONE SHALL be 1 exactly in RUN.
REQ-024 oBOOT_WORD_COUNT SHALL increment on each accepted boot-side write and saturate at 23'h7FFFFF.
REQ-025 The pointers SHALL wrap modulo P_FIFO_DEPTH.

Reset
REQ-026 On inRESET=0 (async) or iRESET_SYNC=1 (sync) the block SHALL enter BOOT, empty the FIFO, and clear the count, the checksum and all read-return registers.
REQ-027 The reset output values SHALL be: oMEM_REQ_VALID=0, oCPU_RD_VALID=0, oBOOT_DONE=0, oIBOOT_REQ_LOCK=0, oCPU_REQ_LOCK=1, data outputs 0.
REQ-028 A reset mid-operation SHALL discard queued requests without issuing them.

Configuration
REQ-029 The block SHALL support macro MIST32_IBOOT_CHECKSUM_EN.
REQ-030 With MIST32_IBOOT_CHECKSUM_EN defined, oBOOT_CHECKSUM SHALL be the mod-2^32 sum of the data of accepted boot-side writes, frozen after BOOT.
REQ-031 Without MIST32_IBOOT_CHECKSUM_EN, oBOOT_CHECKSUM SHALL be constant 32'h0 and no adder is synthesised.

Structure
REQ-032 The FSM state enum (BOOT/DRAIN/RUN) and the memif request struct (dqm, rw, addr, data = 62 bits) SHALL live in shared package memif_pkg.
REQ-033 The FIFO SHALL be sub-module memif_req_fifo (parameterised depth, push/pop, full/empty/count).

Verification
REQ-034 Scenario: after reset, 3 boot writes (addr 0..2, data 32'h11111111, 32'h22222222, 32'h33333333) with iMEM_REQ_LOCK=0 -> 3 oMEM_REQ_VALID pulses in order, each 1 cycle after acceptance, and oBOOT_WORD_COUNT=3.
REQ-035 Scenario: iMEM_REQ_LOCK=1 and 5 boot writes offered -> 4 accepted, oIBOOT_REQ_LOCK=1; then release the lock -> 4 issues, and the 5th is accepted after the first pop.
REQ-036 Scenario: drop iIBOOT_VALID with 2 entries queued -> DRAIN, both LOCKs 1, entries issued, then RUN and oBOOT_DONE=1; a CPU read then sees iMEM_RD_DATA=32'hDEADBEEF on oCPU_RD_DATA 1 cycle later.
REQ-037 Scenario: iRESET_SYNC pulse while 3 entries are queued and the memory is locked -> FIFO empty, no further oMEM_REQ_VALID, state BOOT.
REQ-038 Scenario: with MIST32_IBOOT_CHECKSUM_EN, boot writes 32'hFFFFFFFF and 32'h00000002 -> oBOOT_CHECKSUM=32'h00000001; without the macro -> 0.
